// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency single-outstanding data memory responder for a core load/store unit.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_M1 = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic l_we;
  logic [31:0] l_addr, l_wdata, l_off, c_off, c_wdata;
  logic [3:0] l_be, c_be;
  logic accept, commit, l_bad;
  logic [31:0] mem [DEPTH_WORDS];
  // off is the address relative to BASE_ADDR; BASE_ADDR is aligned so off[1:0] equals addr[1:0]
  function automatic logic fault(input logic [31:0] off, input logic [3:0] b);
    return off[1:0] != 2'b00 || b == 4'b0000 || {1'b0, off} >= SPAN;
  endfunction
  assign gnt_o = rstn_i && state != WAIT;
  assign accept = gnt_o && req_i;
  assign rvalid_o = rstn_i && state == RESP;
  assign l_off = l_addr - BASE_ADDR;
  assign l_bad = fault(l_off, l_be);
  assign err_o = rvalid_o && l_bad;
  assign rdata_o = rvalid_o && !l_bad && !l_we ? mem[l_off[AW+1:2]] : '0;
  // With no wait states the store commits on the accepting edge, so it must use the live inputs
  assign c_off = (WAIT_STATES == 0 ? addr_i : l_addr) - BASE_ADDR;
  assign c_be = WAIT_STATES == 0 ? be_i : l_be;
  assign c_wdata = WAIT_STATES == 0 ? wdata_i : l_wdata;
  assign commit = WAIT_STATES == 0 ? accept && we_i && !fault(c_off, c_be)
                                   : rstn_i && state == WAIT && cnt == 4'd0 && l_we && !l_bad;
  always_comb begin
    state_n = state;
    if (state == WAIT) state_n = cnt == 4'd0 ? RESP : WAIT;
    else if (accept) state_n = WAIT_STATES == 0 ? RESP : WAIT;
    else if (state == RESP) state_n = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      cnt <= '0;
      l_we <= 1'b0;
      l_addr <= '0;
      l_be <= '0;
      l_wdata <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt <= WS_M1;
        l_we <= we_i;
        l_addr <= addr_i;
        l_be <= be_i;
        l_wdata <= wdata_i;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end
  always_ff @(posedge clk_i)
    for (int b = 0; b < 4; b++)
      if (commit && c_be[b]) mem[c_off[AW+1:2]][8*b +: 8] <= c_wdata[8*b +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: checks three responder instances (1, 0 and 3 wait states) against a word-array model.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rstn [3];
  logic req [3];
  logic we [3];
  logic [31:0] addr [3];
  logic [3:0] be [3];
  logic [31:0] wdata [3];
  logic gnt [3];
  logic rvalid [3];
  logic [31:0] rdata [3];
  logic err [3];
  int checks = 0;
  int failures = 0;
  int ws [3] = '{1, 0, 3};
  logic [31:0] mdl [3][16];
  logic [31:0] last_rdata;
  logic last_err;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(16),
      .BASE_ADDR(32'h0000_0000),
      .WAIT_STATES(g == 0 ? 1 : g == 1 ? 0 : 3)
    ) u_dut (
      .clk_i(clk), .rstn_i(rstn[g]), .req_i(req[g]), .we_i(we[g]), .addr_i(addr[g]),
      .be_i(be[g]), .wdata_i(wdata[g]), .gnt_o(gnt[g]), .rvalid_o(rvalid[g]),
      .rdata_o(rdata[g]), .err_o(err[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // One complete request: wait for grant, then measure latency and compare against the model
  task automatic xact(input int k, input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d);
    int n;
    logic bad;
    logic [31:0] exp_rd;
    @(posedge clk); #1;
    req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
    n = 0;
    @(negedge clk);
    while (!gnt[k] && n < 20) begin n++; @(negedge clk); end
    chk("grant_timeout", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    req[k] = 1'b0; we[k] = 1'($urandom); addr[k] = $urandom; be[k] = 4'($urandom); wdata[k] = $urandom;
    n = 0;
    @(negedge clk);
    while (!rvalid[k] && n < 40) begin n++; @(negedge clk); end
    chk("latency", 32'(n), 32'(ws[k]));
    bad = a[1:0] != 2'b00 || b == 4'b0000 || a >= 32'h40;
    exp_rd = (bad || w) ? 32'h0 : mdl[k][a[5:2]];
    chk("err", 32'(err[k]), 32'(bad));
    chk("rdata", rdata[k], exp_rd);
    last_rdata = rdata[k];
    last_err = err[k];
    if (w && !bad)
      for (int i = 0; i < 4; i++) if (b[i]) mdl[k][a[5:2]][8*i +: 8] = d[8*i +: 8];
    @(negedge clk);
    chk("rvalid_pulse", 32'(rvalid[k]), 32'd0);
    chk("rdata_idle", rdata[k], 32'h0);
  endtask
  initial begin
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; be[k] = '0; wdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_gnt", 32'(gnt[k]), 32'd0);
      chk("rst_rvalid", 32'(rvalid[k]), 32'd0);
      chk("rst_err", 32'(err[k]), 32'd0);
      chk("rst_rdata", rdata[k], 32'h0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) rstn[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("gnt_after_rst", 32'(gnt[k]), 32'd1);
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 16; w++) xact(k, 1'b1, 32'(4 * w), 4'hF, $urandom);
    xact(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    xact(0, 1'b0, 32'h10, 4'hF, 32'h0);
    chk("full_store_load", last_rdata, 32'hDEADBEEF);
    xact(0, 1'b1, 32'h10, 4'b0010, 32'h0000_5500);
    xact(0, 1'b0, 32'h10, 4'b0001, 32'h0);
    chk("lane_store_load", last_rdata, 32'hDEAD55EF);
    xact(0, 1'b0, 32'h12, 4'hF, 32'h0);
    chk("misaligned_err", 32'(last_err), 32'd1);
    chk("misaligned_rdata", last_rdata, 32'h0);
    xact(0, 1'b1, 32'h40, 4'hF, 32'h12345678);
    chk("range_err", 32'(last_err), 32'd1);
    xact(0, 1'b0, 32'h0, 4'hF, 32'h0);
    chk("range_unchanged", last_rdata, mdl[0][0]);
    // Store immediately followed by a load to the same word accepted in the store's response cycle
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; be[0] = 4'hF; wdata[0] = 32'hCAFEF00D;
    @(negedge clk); chk("b2b_gnt_idle", 32'(gnt[0]), 32'd1);
    @(posedge clk); #1; we[0] = 1'b0; wdata[0] = $urandom;
    @(negedge clk); chk("b2b_gnt_wait", 32'(gnt[0]), 32'd0); chk("b2b_no_rvalid", 32'(rvalid[0]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_st_rvalid", 32'(rvalid[0]), 32'd1);
    chk("b2b_st_err", 32'(err[0]), 32'd0);
    chk("b2b_st_rdata", rdata[0], 32'h0);
    chk("b2b_gnt_resp", 32'(gnt[0]), 32'd1);
    @(posedge clk); #1; req[0] = 1'b0;
    @(negedge clk); chk("b2b_wait_rvalid", 32'(rvalid[0]), 32'd0);
    @(negedge clk);
    chk("b2b_ld_rvalid", 32'(rvalid[0]), 32'd1);
    chk("b2b_ld_rdata", rdata[0], 32'hCAFEF00D);
    mdl[0][12] = 32'hCAFEF00D;
    // Zero wait states with req held high: a load is granted every cycle, responses in order
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0; be[1] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) chk("ws0_gnt", 32'(gnt[1]), 32'd1);
      chk("ws0_rvalid", 32'(rvalid[1]), 32'(i > 0));
      if (i > 0) chk("ws0_rdata", rdata[1], mdl[1][i-1]);
      @(posedge clk); #1;
      if (i < 2) addr[1] = 32'(4 * (i + 1));
      else req[1] = 1'b0;
    end
    // Reset during the wait period of a store must cancel it
    xact(2, 1'b1, 32'h20, 4'hF, 32'h11112222);
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; be[2] = 4'hF; wdata[2] = 32'hAAAAAAAA;
    @(negedge clk); chk("ws3_gnt", 32'(gnt[2]), 32'd1);
    @(posedge clk); #1; req[2] = 1'b0;
    @(negedge clk); chk("ws3_wait_gnt", 32'(gnt[2]), 32'd0);
    @(posedge clk); #1; rstn[2] = 1'b0;
    @(negedge clk);
    chk("mid_rst_gnt", 32'(gnt[2]), 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid[2]), 32'd0);
    chk("mid_rst_rdata", rdata[2], 32'h0);
    @(posedge clk); #1; rstn[2] = 1'b1;
    @(negedge clk); chk("mid_rst_gnt_after", 32'(gnt[2]), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); chk("mid_rst_no_resp", 32'(rvalid[2]), 32'd0);
    end
    xact(2, 1'b0, 32'h20, 4'hF, 32'h0);
    chk("mid_rst_kept", last_rdata, 32'h11112222);
    for (int k = 0; k < 3; k++)
      for (int n = 0; n < (k == 2 ? 40 : 150); n++) begin
        a = {24'h0, 3'($urandom_range(0, 7)) == 3'd0 ? 8'($urandom_range(0, 127))
                                                    : {1'b0, 5'($urandom_range(0, 31)), 2'b00}};
        xact(k, 1'($urandom), a, 4'($urandom_range(0, 15)), $urandom);
      end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
